// File: rtl/ebus_xfer.sv
// EBUS transfer controller: sequences device select, function code, the
// demand/transfer handshake and the timeout for one EBOX<->device transfer.
module ebus_xfer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DEV_W          = 7
) (
    input  logic             masterClk,
    input  logic             CROBAR,
    input  logic             start,
    input  logic             isRead,
    input  logic [2:0]       funcCode,
    input  logic [DEV_W-1:0] devSel,
    input  logic [35:0]      wrData,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [35:0]      rdData,
    output logic [DEV_W-1:0] ebusCS,
    output logic [2:0]       ebusFunc,
    output logic             ebusDemand,
    output logic [35:0]      ebusDataOut,
    output logic             ebusDataOE,
    input  logic             ebusXfer,
    input  logic [35:0]      ebusDataIn
);

    // Counter must hold TIMEOUT_CYCLES-1; one spare bit keeps odd sizes safe.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_DEMAND  = 3'd2,
        S_RELEASE = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               is_read_q, is_read_d;
    logic [2:0]         func_q, func_d;
    logic [DEV_W-1:0]   dev_q, dev_d;
    logic [35:0]        wr_data_q, wr_data_d;
    logic [35:0]        rd_data_q, rd_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               abort_q, abort_d;
    logic               drive_bus;

    // State register and latched transfer fields; CROBAR clears everything.
    always_ff @(posedge masterClk) begin
        if (CROBAR) begin
            state_q   <= S_IDLE;
            is_read_q <= 1'b0;
            func_q    <= '0;
            dev_q     <= '0;
            wr_data_q <= '0;
            rd_data_q <= '0;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_read_q <= is_read_d;
            func_q    <= func_d;
            dev_q     <= dev_d;
            wr_data_q <= wr_data_d;
            rd_data_q <= rd_data_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
        end
    end

    // Next-state logic: handshake sequencing, timeout counting, read capture.
    always_comb begin
        state_d   = state_q;
        is_read_d = is_read_q;
        func_d    = func_q;
        dev_d     = dev_q;
        wr_data_d = wr_data_q;
        rd_data_d = rd_data_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;

        case (state_q)
            S_IDLE: begin
                // Requests are only taken here; a start elsewhere is dropped.
                if (start) begin
                    is_read_d = isRead;
                    func_d    = funcCode;
                    dev_d     = devSel;
                    wr_data_d = wrData;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = CNT_ZERO;
                abort_d = 1'b0;
                state_d = S_DEMAND;
            end
            S_DEMAND: begin
                cnt_d = cnt_q + CNT_ONE;
                // A late acknowledge still wins over the timeout in the same cycle.
                if (ebusXfer) begin
                    if (is_read_q) begin
                        rd_data_d = ebusDataIn;
                    end
                    cnt_d   = CNT_ZERO;
                    state_d = S_RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    abort_d = 1'b1;
                    if (is_read_q) begin
                        rd_data_d = '0;
                    end
                    state_d = S_FINISH;
                end
            end
            S_RELEASE: begin
                cnt_d = cnt_q + CNT_ONE;
                // Captured read data is kept even if the device never lets go.
                if (!ebusXfer) begin
                    state_d = S_FINISH;
                end else if (cnt_q == CNT_LAST) begin
                    abort_d = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus and status outputs decoded from the registered state.
    always_comb begin
        drive_bus   = (state_q == S_SETUP) || (state_q == S_DEMAND) ||
                      (state_q == S_RELEASE);
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_FINISH);
        timeout     = (state_q == S_FINISH) && abort_q;
        ebusDemand  = (state_q == S_DEMAND);
        ebusCS      = drive_bus ? dev_q : '0;
        ebusFunc    = drive_bus ? func_q : 3'b000;
        ebusDataOE  = drive_bus && !is_read_q;
        ebusDataOut = (drive_bus && !is_read_q) ? wr_data_q : 36'h0;
        rdData      = rd_data_q;
    end

endmodule

// File: tb/tb_ebus_xfer.sv
// Randomized bench for ebus_xfer with a transaction-level device/reference model.
module tb_ebus_xfer;

    localparam int TMO   = 64;
    localparam int DEV_W = 7;

    logic             masterClk = 1'b0;
    logic             CROBAR;
    logic             start;
    logic             isRead;
    logic [2:0]       funcCode;
    logic [DEV_W-1:0] devSel;
    logic [35:0]      wrData;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [35:0]      rdData;
    logic [DEV_W-1:0] ebusCS;
    logic [2:0]       ebusFunc;
    logic             ebusDemand;
    logic [35:0]      ebusDataOut;
    logic             ebusDataOE;
    logic             ebusXfer;
    logic [35:0]      ebusDataIn;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [35:0] exp_rd;

    ebus_xfer #(.TIMEOUT_CYCLES(TMO), .DEV_W(DEV_W)) dut (
        .masterClk   (masterClk),
        .CROBAR      (CROBAR),
        .start       (start),
        .isRead      (isRead),
        .funcCode    (funcCode),
        .devSel      (devSel),
        .wrData      (wrData),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .rdData      (rdData),
        .ebusCS      (ebusCS),
        .ebusFunc    (ebusFunc),
        .ebusDemand  (ebusDemand),
        .ebusDataOut (ebusDataOut),
        .ebusDataOE  (ebusDataOE),
        .ebusXfer    (ebusXfer),
        .ebusDataIn  (ebusDataIn)
    );

    always #5 masterClk = ~masterClk;

    function automatic logic [35:0] rnd36();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[35:0];
    endfunction

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare every output against one expected snapshot.
    task automatic chk_all(input string ph, input bit b, input bit dn, input bit to,
                           input bit dm, input bit oe, input logic [DEV_W-1:0] cs,
                           input logic [2:0] fc, input logic [35:0] dout);
        chk({ph, ".busy"},    36'(busy),        36'(b));
        chk({ph, ".done"},    36'(done),        36'(dn));
        chk({ph, ".timeout"}, 36'(timeout),     36'(to));
        chk({ph, ".demand"},  36'(ebusDemand),  36'(dm));
        chk({ph, ".oe"},      36'(ebusDataOE),  36'(oe));
        chk({ph, ".cs"},      36'(ebusCS),      36'(cs));
        chk({ph, ".func"},    36'(ebusFunc),    36'(fc));
        chk({ph, ".dout"},    ebusDataOut,      dout);
        chk({ph, ".rd"},      rdData,           exp_rd);
    endtask

    // Drive junk request fields; used while the DUT must ignore start.
    task automatic drive_noise(input bit on);
        start = on;
        if (on) begin
            isRead   = $urandom_range(0, 1) == 1;
            funcCode = 3'($urandom_range(0, 7));
            devSel   = 7'($urandom_range(0, 127));
            wrData   = 36'h123456789;
        end
    endtask

    // One transfer from IDLE back to IDLE. The device acknowledges in demand
    // cycle d (0-based; d >= TMO means never) and holds xfer for r release
    // cycles (r >= TMO means stuck). Called and returns on a negedge in IDLE.
    task automatic run_xfer(input bit rd, input logic [2:0] fc, input logic [DEV_W-1:0] dv,
                            input logic [35:0] wd, input logic [35:0] cap,
                            input int d, input int r, input bit noise);
        int nd, nr;
        bit ab;
        logic [35:0] dout;
        dout     = rd ? 36'h0 : wd;
        start    = 1'b1;
        isRead   = rd;
        funcCode = fc;
        devSel   = dv;
        wrData   = wd;
        ebusXfer = 1'b0;
        @(negedge masterClk);
        drive_noise(noise);
        chk_all("setup", 1, 0, 0, 0, !rd, dv, fc, dout);

        nd = (d < TMO) ? d + 1 : TMO;
        ab = (d >= TMO);
        for (int i = 0; i < nd; i++) begin
            @(negedge masterClk);
            chk_all("demand", 1, 0, 0, 1, !rd, dv, fc, dout);
            drive_noise(noise && ($urandom_range(0, 1) == 1));
            if (i == d) begin
                ebusXfer   = 1'b1;
                ebusDataIn = cap;
            end else begin
                ebusXfer   = 1'b0;
                ebusDataIn = rnd36();
            end
        end

        if (!ab) begin
            if (rd) exp_rd = cap;
            nr = (r < TMO) ? r + 1 : TMO;
            ab = (r >= TMO);
            for (int j = 0; j < nr; j++) begin
                @(negedge masterClk);
                chk_all("release", 1, 0, 0, 0, !rd, dv, fc, dout);
                drive_noise(noise && ($urandom_range(0, 1) == 1));
                ebusXfer   = (j < r);
                ebusDataIn = rnd36();
            end
        end else if (rd) begin
            exp_rd = 36'h0;
        end

        @(negedge masterClk);
        chk_all("finish", 1, 1, ab, 0, 0, '0, 3'b000, 36'h0);
        ebusXfer = 1'b0;
        drive_noise(noise);
        @(negedge masterClk);
        chk_all("idle", 0, 0, 0, 0, 0, '0, 3'b000, 36'h0);
        start = 1'b0;
    endtask

    // Abort with CROBAR after k demand cycles, then check the quiet aftermath.
    task automatic run_reset_mid(input bit rd, input int k);
        start    = 1'b1;
        isRead   = rd;
        funcCode = 3'b101;
        devSel   = 7'o55;
        wrData   = rnd36();
        ebusXfer = 1'b0;
        @(negedge masterClk);
        start = 1'b0;
        for (int i = 0; i < k; i++) @(negedge masterClk);
        chk({"rstmid.demand"}, 36'(ebusDemand), 36'(1));
        CROBAR = 1'b1;
        @(negedge masterClk);
        CROBAR = 1'b0;
        exp_rd = 36'h0;
        chk_all("rstmid.after", 0, 0, 0, 0, 0, '0, 3'b000, 36'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge masterClk);
            chk_all("rstmid.quiet", 0, 0, 0, 0, 0, '0, 3'b000, 36'h0);
        end
    endtask

    initial begin
        CROBAR     = 1'b1;
        start      = 1'b0;
        isRead     = 1'b0;
        funcCode   = 3'b000;
        devSel     = '0;
        wrData     = 36'h0;
        ebusXfer   = 1'b0;
        ebusDataIn = 36'h0;
        exp_rd     = 36'h0;
        repeat (3) @(negedge masterClk);
        chk_all("reset", 0, 0, 0, 0, 0, '0, 3'b000, 36'h0);
        CROBAR = 1'b0;
        @(negedge masterClk);
        chk_all("reset.idle", 0, 0, 0, 0, 0, '0, 3'b000, 36'h0);

        // Seed rdData with a known read so a following write can show it is untouched.
        run_xfer(1, 3'b001, 7'o10, 36'h0, 36'h0abcdef01, 0, 0, 0);
        // Write, fast device.
        run_xfer(0, 3'b010, 7'o04, 36'h555555555, rnd36(), 2, 1, 0);
        // Read capture.
        run_xfer(1, 3'b011, 7'o10, 36'h0, 36'h987654321, 1, 0, 0);
        // Demand timeout on a read.
        run_xfer(1, 3'b100, 7'o21, 36'h0, rnd36(), TMO + 5, 0, 0);
        // Stuck xfer on a write.
        run_xfer(0, 3'b110, 7'o33, rnd36(), rnd36(), 1, TMO + 5, 0);
        // Acknowledge in the last demand cycle and release in the last release cycle.
        run_xfer(1, 3'b111, 7'o77, 36'h0, 36'hfedcba987, TMO - 1, TMO - 1, 0);
        // Start while busy is ignored, then back-to-back.
        run_xfer(0, 3'b010, 7'o04, 36'h0aaaaaaaa, rnd36(), 3, 1, 1);
        run_xfer(0, 3'b001, 7'o05, 36'h0f0f0f0f0, rnd36(), 0, 0, 0);
        // Reset in the middle of DEMAND, then normal operation resumes.
        run_reset_mid(1, 2);
        run_xfer(1, 3'b011, 7'o12, 36'h0, 36'h111111111, 0, 2, 0);

        for (int n = 0; n < 40; n++) begin
            int d, r;
            d = ($urandom_range(0, 7) == 0) ? 60 + $urandom_range(0, 8) : $urandom_range(0, 4);
            r = ($urandom_range(0, 7) == 0) ? 60 + $urandom_range(0, 8) : $urandom_range(0, 3);
            run_xfer($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                     7'($urandom_range(0, 127)), rnd36(), rnd36(), d, r,
                     $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) @(negedge masterClk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
